// File: rtl/leaper_attack_gen_if.sv
// Request/result handshake bundle for the leaper attack generator.
// out_multi exists only when LEAPER_MULTI_EN is defined.
interface leaper_attack_gen_if #(
    parameter int N  = 64,
    parameter int CW = 7
);
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_pieces;
    logic          in_mode;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_attack;
    logic [CW-1:0] out_count;
`ifdef LEAPER_MULTI_EN
    logic [N-1:0]  out_multi;
`endif

    modport master (
        output in_valid, in_pieces, in_mode, out_ready,
        input  in_ready, out_valid, out_attack, out_count
`ifdef LEAPER_MULTI_EN
        , out_multi
`endif
    );

    modport slave (
        input  in_valid, in_pieces, in_mode, out_ready,
        output in_ready, out_valid, out_attack, out_count
`ifdef LEAPER_MULTI_EN
        , out_multi
`endif
    );
endinterface

// File: rtl/leaper_attack_gen.sv
// Serial knight/king attack-map generator, one piece per cycle.
// Define LEAPER_MULTI_EN for the squares-attacked-twice map (out_multi).
module leaper_attack_gen #(
    parameter int BOARD_W = 8,
    parameter int BOARD_H = 8
) (
    input  logic               clk,
    input  logic               reset,
    leaper_attack_gen_if.slave bus
);
    localparam int N  = BOARD_W * BOARD_H;
    localparam int CW = $clog2(N + 1);

    localparam int NDF [8] = '{ 1,  2,  2,  1, -1, -2, -2, -1};
    localparam int NDR [8] = '{ 2,  1, -1, -2, -2, -1,  1,  2};
    localparam int KDF [8] = '{ 1,  1,  0, -1, -1, -1,  0,  1};
    localparam int KDR [8] = '{ 0,  1,  1,  1,  0, -1, -1, -1};

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  work_q;
    logic          mode_q;
    logic [N-1:0]  acc_q;
    logic [CW-1:0] cnt_q;
    logic [N-1:0]  low;
    logic [N-1:0]  npat, kpat, pat;
`ifdef LEAPER_MULTI_EN
    logic [N-1:0]  multi_q;
`endif

    // Source squares whose file stays on the board after a df step.
    function automatic logic [N-1:0] file_mask(input int df);
        logic [N-1:0] m;
        m = '0;
        for (int s = 0; s < N; s++) begin
            m[s] = ((s % BOARD_W) + df >= 0) &&
                   ((s % BOARD_W) + df < BOARD_W);
        end
        return m;
    endfunction

    // Rank overflow simply shifts out of the N-bit vector.
    function automatic logic [N-1:0] leap(
        input logic [N-1:0] sq,
        input int           df,
        input int           dr
    );
        int           sh;
        logic [N-1:0] src;
        sh  = dr * BOARD_W + df;
        src = sq & file_mask(df);
        if (sh >= 0) return src << sh;
        else         return src >> (-sh);
    endfunction

    always_comb begin
        low  = work_q & (-work_q);
        npat = '0;
        kpat = '0;
        for (int k = 0; k < 8; k++) begin
            npat = npat | leap(low, NDF[k], NDR[k]);
            kpat = kpat | leap(low, KDF[k], KDR[k]);
        end
        pat = mode_q ? kpat : npat;
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_d = SCAN;
            end
            SCAN: begin
                if (work_q == '0) state_d = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            work_q  <= '0;
            mode_q  <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
`ifdef LEAPER_MULTI_EN
            multi_q <= '0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        work_q  <= bus.in_pieces;
                        mode_q  <= bus.in_mode;
                        acc_q   <= '0;
                        cnt_q   <= '0;
`ifdef LEAPER_MULTI_EN
                        multi_q <= '0;
`endif
                    end
                end
                SCAN: begin
                    if (work_q != '0) begin
                        work_q  <= work_q & ~low;
                        acc_q   <= acc_q | pat;
                        cnt_q   <= cnt_q + CW'(1);
`ifdef LEAPER_MULTI_EN
                        multi_q <= multi_q | (acc_q & pat);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.out_attack = acc_q;
    assign bus.out_count  = cnt_q;
`ifdef LEAPER_MULTI_EN
    assign bus.out_multi  = multi_q;
`endif
endmodule
